fsk_zc_demod: RTL
=================

Name: fsk_zc_demod

Overview:
- Receive-side counterpart to the transmit cosine/sine generation path. It takes signed tone samples (the same SinSize-wide format the TX tables produce) and recovers FSK symbols.
- Method: counts sign changes (zero crossings) over one symbol window, then slices the count against a threshold to give one bit per window.
- Sits after the RX sample front end and feeds the bit/frame deframer.

Parameters:
- SIN_SIZE, 13, width of the signed two's-complement input sample (matches `SinSize).
- SPS, 16, valid samples per symbol window (≥2).
- THRESH, 4, crossing count at or above which a window decodes as bit 1.
- CW, $clog2(SPS+1), width of the crossing counter and count output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  demodulator run control.
- sync_start  input  1  one-cycle pulse marking the first sample of a new symbol window.
- sample_in  input  SIN_SIZE  signed tone sample.
- sample_valid  input  1  sample_in is valid this cycle.
- bit_out  output  1  decided bit; held until the next decision.
- bit_valid  output  1  one-cycle strobe when bit_out is updated.
- crossings  output  CW  crossing count of the last completed window; held.
- in_symbol  output  1  high while a window is partially accumulated.

Behaviour:
- Reset (reset=1 at clk edge) clears all outputs and internal state to 0:
  - Outputs: bit_out, bit_valid, crossings, in_symbol.
  - Internal: window counter, crossing accumulator, prev_sign, prev_ok.
  - State goes to IDLE. Reset overrides every other input.
- Sign rule: sign = sample_in[SIN_SIZE-1]. Zero counts as positive. No hysteresis.
- A crossing is an accepted sample whose sign differs from prev_sign while prev_ok=1.
- On every accepted sample: prev_sign <= sign, prev_ok <= 1.
- States:
  - IDLE: enable=0. Samples are ignored. Counters are held at 0. prev_ok=0.
  - RUN: entered on the first cycle with enable=1. Counters start at 0 and prev_ok=0, so the first sample never produces a crossing.
  - RUN -> IDLE whenever enable=0. The partial window is discarded, no bit_valid is issued, and in_symbol=0 next cycle.
- Accepting a sample (RUN and sample_valid=1):
  - Window counter increments.
  - Accumulator adds 1 on a crossing.
  - in_symbol=1.
- Window completion:
  - Occurs when the SPS-th sample of the window is accepted. A crossing on that sample counts.
  - On the next clk edge (latency 1 cycle from the last sample):
    - crossings <= final count.
    - bit_out <= (final count >= THRESH).
    - bit_valid = 1 for exactly one cycle.
    - Window counter and accumulator clear; in_symbol=0.
  - prev_sign/prev_ok are kept across window boundaries, so a crossing between windows counts in the new window.
- sync_start (in RUN):
  - Clears the window counter and accumulator with no decision and no bit_valid.
  - If sample_valid is high in the same cycle, that sample is the first sample of the new window. Its crossing against the retained prev_sign counts.
  - If sync_start and a window-completing sample coincide, sync_start wins: no decision, and the sample starts the new window.
- sample_valid=0 cycles: no state change. The window spans SPS valid samples regardless of gaps.
- Accumulator max is SPS; no overflow is possible with the CW width.
- enable=1 with sync_start never pulsed: windows free-run from the first accepted sample.

Test Plan:
- Reset mid-window: reset asserted after 5 samples -> all outputs 0 next cycle. Next enabled window needs a full 16 samples and produces no spurious bit_valid.
- High tone: SPS=16, THRESH=4, enable=1, continuous pattern +2047,+2047,-2047,-2047 repeating ->
  - window 1: crossings=7, bit_out=1, bit_valid exactly 1 cycle after the 16th sample;
  - window 2: crossings=8, bit_out=1.
- Low tone: 8 positive then 8 negative samples repeating, after one prior window ->
  - window 1: crossings=1, bit_out=0;
  - windows thereafter: crossings=2, bit_out=0.
- Gapped valid: high-tone stream with sample_valid low every other cycle -> identical crossings/bits. bit_valid only after 16 valid samples.
- sync_start: pulsed with the 10th sample of a window -> no bit_valid; the next decision comes 15 samples later. Pulsed with the 16th sample -> no decision, and the new window starts at that sample.
- Enable drop: enable=0 after 8 samples -> in_symbol=0 and no bit_valid. Re-enable -> the first sample counts no crossing, even with opposite sign; zero-valued samples are treated as positive.

Source files
------------

// File: rtl/fsk_zc_demod.sv
// Zero-crossing FSK demodulator: counts sign changes of the incoming tone over one
// symbol window of SPS valid samples and slices the count against THRESH.
module fsk_zc_demod #(
    parameter int SIN_SIZE = 13,
    parameter int SPS      = 16,
    parameter int THRESH   = 4,
    parameter int CW       = $clog2(SPS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sync_start,
    input  logic [SIN_SIZE-1:0] sample_in,
    input  logic                sample_valid,
    output logic                bit_out,
    output logic                bit_valid,
    output logic [CW-1:0]       crossings,
    output logic                in_symbol
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0]              LAST_IDX   = CW'(SPS - 1);
    localparam logic [CW-1:0]              THRESH_CNT = CW'(THRESH);
    localparam logic [CW-1:0]              CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]              CNT_ZERO   = '0;
    localparam logic signed [SIN_SIZE-1:0] ZERO_SMP   = '0;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] win_cnt_r;
    logic [CW-1:0] win_cnt_next_s;
    logic [CW-1:0] acc_r;
    logic [CW-1:0] acc_next_s;
    logic [CW-1:0] final_cnt_s;
    logic          prev_sign_r;
    logic          prev_sign_next_s;
    logic          prev_ok_r;
    logic          prev_ok_next_s;
    logic          run_s;
    logic          accept_s;
    logic          sign_s;
    logic          cross_s;
    logic          done_s;

    logic          bit_out_r;
    logic          bit_valid_r;
    logic [CW-1:0] crossings_r;
    logic          in_symbol_r;

    // Run-control state transition
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (enable) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Sample acceptance, crossing detection, window accumulation and decision
    always_comb begin
        win_cnt_next_s   = win_cnt_r;
        acc_next_s       = acc_r;
        prev_sign_next_s = prev_sign_r;
        prev_ok_next_s   = prev_ok_r;
        done_s           = 1'b0;

        run_s       = (state_r == RUN) && enable;
        accept_s    = run_s && sample_valid;
        // zero samples count as positive, so only strictly negative values set the sign
        sign_s      = ($signed(sample_in) < ZERO_SMP) ? 1'b1 : 1'b0;
        cross_s     = accept_s && prev_ok_r && (sign_s != prev_sign_r);
        final_cnt_s = acc_r + (cross_s ? CNT_ONE : CNT_ZERO);

        if (!run_s) begin
            win_cnt_next_s = CNT_ZERO;
            acc_next_s     = CNT_ZERO;
        end else if (sync_start) begin
            // a coincident sample becomes the first of the fresh window, even if it would have completed the old one
            if (accept_s) begin
                win_cnt_next_s = CNT_ONE;
                acc_next_s     = cross_s ? CNT_ONE : CNT_ZERO;
            end else begin
                win_cnt_next_s = CNT_ZERO;
                acc_next_s     = CNT_ZERO;
            end
        end else if (accept_s) begin
            if (win_cnt_r == LAST_IDX) begin
                done_s         = 1'b1;
                win_cnt_next_s = CNT_ZERO;
                acc_next_s     = CNT_ZERO;
            end else begin
                win_cnt_next_s = win_cnt_r + CNT_ONE;
                acc_next_s     = final_cnt_s;
            end
        end else begin
            win_cnt_next_s = win_cnt_r;
            acc_next_s     = acc_r;
        end

        // sign history survives window boundaries but not a drop out of RUN
        if (!run_s) begin
            prev_ok_next_s   = 1'b0;
            prev_sign_next_s = 1'b0;
        end else if (accept_s) begin
            prev_ok_next_s   = 1'b1;
            prev_sign_next_s = sign_s;
        end else begin
            prev_ok_next_s   = prev_ok_r;
            prev_sign_next_s = prev_sign_r;
        end
    end

    // State, datapath and registered output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            win_cnt_r   <= CNT_ZERO;
            acc_r       <= CNT_ZERO;
            prev_sign_r <= 1'b0;
            prev_ok_r   <= 1'b0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            crossings_r <= CNT_ZERO;
            in_symbol_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            win_cnt_r   <= win_cnt_next_s;
            acc_r       <= acc_next_s;
            prev_sign_r <= prev_sign_next_s;
            prev_ok_r   <= prev_ok_next_s;
            bit_valid_r <= done_s;
            in_symbol_r <= (win_cnt_next_s != CNT_ZERO);
            if (done_s) begin
                crossings_r <= final_cnt_s;
                bit_out_r   <= (final_cnt_s >= THRESH_CNT);
            end else begin
                crossings_r <= crossings_r;
                bit_out_r   <= bit_out_r;
            end
        end
    end

    assign bit_out   = bit_out_r;
    assign bit_valid = bit_valid_r;
    assign crossings = crossings_r;
    assign in_symbol = in_symbol_r;

endmodule
